// File: rtl/clk_div_monitor_pkg.sv
// clk_div_monitor_pkg: state encoding and nominal divided-clock timing shared with the divider bench
package clk_div_monitor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;
  localparam int DEF_EXP_HALF = 11;
  localparam int DEF_TOL = 1;
endpackage

// File: rtl/clk_div_monitor_sync_edge_det.sv
// clk_div_monitor_sync_edge_det: synchronizer chain plus edge register producing registered rise/fall strobes
module clk_div_monitor_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: edge strobes, half-period measurement, lock detection and sticky error for a divided clock
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_HALF = DEF_EXP_HALF,
  parameter int TOL = DEF_TOL,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             div_clk_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] half_period_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             err_o,
  input  logic             err_clr_i
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W:0] HI = (CNT_W + 1)'(EXP_HALF + TOL);
  localparam logic [CNT_W:0] LO = (CNT_W + 1)'(EXP_HALF > TOL ? EXP_HALF - TOL : 0);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat, half_d;
  logic [GW-1:0] good_q, good_d;
  logic [CNT_W:0] cnt_x;
  logic rise_s, fall_s, edge_s, in_tol, timeout, mv_d, err_set;
  clk_div_monitor_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d(div_clk_i),
    .rise(rise_s),
    .fall(fall_s)
  );
  assign rise_o = rise_s & en_i;
  assign fall_o = fall_s & en_i;
  assign edge_s = rise_o | fall_o;
  assign locked_o = state_q == LOCKED;
  // Widened by one bit so EXP_HALF+TOL never wraps against the counter
  assign cnt_x = {1'b0, cnt_q};
  assign in_tol = cnt_x >= LO && cnt_x <= HI;
  assign timeout = cnt_x > HI;
  assign cnt_sat = &cnt_q ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = edge_s ? CNT_W'(1) : cnt_sat;
    good_d = good_q;
    half_d = half_period_o;
    mv_d = 1'b0;
    err_set = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d = '0;
      good_d = '0;
    end else if (state_q == IDLE) begin
      cnt_d = edge_s ? CNT_W'(1) : '0;
      good_d = '0;
      state_d = edge_s ? MEASURE : IDLE;
    end else if (edge_s) begin
      half_d = cnt_q;
      mv_d = 1'b1;
      if (!in_tol) begin
        good_d = '0;
        err_set = state_q == LOCKED;
        state_d = MEASURE;
      end else if (state_q == MEASURE) begin
        good_d = good_q + 1'b1;
        state_d = good_q == GW'(LOCK_COUNT - 1) ? LOCKED : MEASURE;
      end
    end else if (state_q == LOCKED && timeout) begin
      err_set = 1'b1;
      good_d = '0;
      state_d = MEASURE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      good_q <= '0;
      half_period_o <= '0;
      meas_valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      good_q <= good_d;
      half_period_o <= half_d;
      meas_valid_o <= mv_d;
      err_o <= err_set | (err_o & ~err_clr_i);
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed divided-clock patterns with a scoreboard of expected measurements
module tb_clk_div_monitor;
  localparam int CNT_W = 11;
  typedef struct {
    int   half;
    logic lk;
    logic er;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, div = 1'b0, err_clr = 1'b0;
  logic rise, fall, meas_valid, locked, err;
  logic [CNT_W-1:0] half_period;
  exp_t q[$];
  exp_t e_m;
  int vecs = 0, errs = 0, since = 0;
  logic seen;
  clk_div_monitor dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .div_clk_i(div),
    .rise_o(rise),
    .fall_o(fall),
    .half_period_o(half_period),
    .meas_valid_o(meas_valid),
    .locked_o(locked),
    .err_o(err),
    .err_clr_i(err_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL meas_unexpected: half_period_o=%0d but no measurement expected", half_period);
      end else begin
        e_m = q.pop_front();
        if (half_period !== CNT_W'(e_m.half) || locked !== e_m.lk || err !== e_m.er) begin
          errs++;
          $display("FAIL meas: got half=%0d locked=%b err=%b, expected half=%0d locked=%b err=%b",
                   half_period, locked, err, e_m.half, e_m.lk, e_m.er);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic flip();
    div = ~div;
    since = 0;
  endtask
  task automatic hp(input int n, input logic lk, input logic er);
    while (since < n) tick();
    q.push_back('{half: n, lk: lk, er: er});
    flip();
  endtask
  task automatic wait_to(input int n);
    while (since < n) tick();
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_outputs", {rise, fall, meas_valid, locked, err}, 0);
    chk("reset_half", 32'(half_period), 0);
    rst = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    // Lock on a steady 11-cycle half-period and check strobe latency
    flip();
    tick(); tick();
    chk("rise_early", 32'(rise), 0);
    tick();
    chk("rise_latency", 32'(rise), 1);
    tick();
    chk("rise_one_cycle", 32'(rise), 0);
    hp(11, 0, 0);
    wait_to(3);
    chk("fall_latency", 32'(fall), 1);
    hp(11, 0, 0);
    hp(11, 0, 0);
    hp(11, 1, 0);
    hp(11, 1, 0);
    wait_to(6);
    chk("locked_steady", {locked, err}, 2'b10);
    // Long half-period breaks lock; relock leaves error sticky
    hp(15, 0, 1);
    hp(11, 0, 1);
    hp(11, 0, 1);
    hp(11, 0, 1);
    hp(11, 1, 1);
    wait_to(6);
    chk("err_sticky_relock", {locked, err}, 2'b11);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clear", 32'(err), 0);
    // Stopped clock: timeout coincides with err_clr, set must win
    wait_to(16);
    chk("no_early_timeout", {locked, err}, 2'b10);
    err_clr = 1'b1;
    tick();
    chk("timeout_set_wins", {locked, err}, 2'b01);
    chk("timeout_half_held", 32'(half_period), 11);
    tick();
    err_clr = 1'b0;
    chk("err_clr_after", 32'(err), 0);
    // Tolerance edges: 10/12 count as good, 9 resets progress quietly
    hp(20, 0, 0);
    hp(10, 0, 0);
    hp(12, 0, 0);
    hp(10, 0, 0);
    hp(9, 0, 0);
    hp(12, 0, 0);
    hp(10, 0, 0);
    hp(12, 0, 0);
    hp(10, 1, 0);
    wait_to(6);
    chk("tol_locked", {locked, err}, 2'b10);
    // Reset while locked
    rst = 1'b1;
    div = 1'b0;
    tick();
    chk("rst_mid_outputs", {rise, fall, meas_valid, locked, err}, 0);
    chk("rst_mid_half", 32'(half_period), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    flip();
    hp(11, 0, 0);
    hp(11, 0, 0);
    hp(11, 0, 0);
    hp(11, 1, 0);
    wait_to(6);
    chk("relock_after_rst", 32'(locked), 1);
    // Disable: IDLE, no strobes, half-period held, first re-enabled edge unmeasured
    en = 1'b0;
    tick();
    chk("disable_unlock", 32'(locked), 0);
    chk("disable_half_held", 32'(half_period), 11);
    flip();
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= rise | fall | meas_valid;
    end
    chk("disabled_no_strobe", 32'(seen), 0);
    en = 1'b1;
    repeat (3) tick();
    flip();
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= meas_valid;
    end
    chk("first_edge_unmeasured", 32'(seen), 0);
    hp(11, 0, 0);
    hp(11, 0, 0);
    wait_to(8);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receiving end of the divided-clock path: takes a slow divided clock (e.g. the 50 MHz / 22 output of the clock divider) into the clk_i domain.
- Synchronizes it and emits single-cycle rise/fall strobes, which downstream logic uses as clock enables instead of clocking on the divided signal.
- Measures every half-period, declares lock once the period is stable, and flags drift, glitches or a stopped clock with a sticky error.

Parameters:
- CNT_W, 11, width of the half-period counter and measurement output.
- SYNC_STAGES, 2, number of synchronizer flops on div_clk_i (minimum 2).
- EXP_HALF, 11, expected half-period in clk_i cycles.
- TOL, 1, allowed deviation of ±TOL cycles from EXP_HALF.
- LOCK_COUNT, 4, number of consecutive in-tolerance measurements required to lock.

Ports:
- clk_i  in  1  system clock, 50 MHz
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  monitor enable
- div_clk_i  in  1  divided clock under observation, asynchronous-safe
- rise_o  out  1  one-cycle strobe on each synchronized rising edge
- fall_o  out  1  one-cycle strobe on each synchronized falling edge
- half_period_o  out  CNT_W  last measured edge-to-edge distance, in clk_i cycles
- meas_valid_o  out  1  one-cycle strobe when half_period_o updates
- locked_o  out  1  high while in the LOCKED state
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset: all synchronizer flops, the edge register, counters and every output go to 0; state goes to IDLE. Reset is synchronous (clk_i edge only) and overrides everything, including mid-measurement.
- Synchronizer and edge register update on every clock regardless of en_i.
- Edge latency: a div_clk_i transition produces rise_o or fall_o exactly SYNC_STAGES+1 clk_i cycles later. Strobes are suppressed while en_i=0.
- Edge counter cnt:
  - On an edge, cnt loads 1; otherwise cnt increments, saturating at 2^CNT_W-1.
  - For edges at cycles t0 and t1, cnt_q at t1 equals t1-t0.
- FSM (states IDLE, MEASURE, LOCKED):
  - IDLE: cnt is held at 0. The first edge moves to MEASURE and starts cnt; no measurement is taken on that edge.
  - MEASURE and LOCKED, on each edge: half_period_o <= cnt_q and meas_valid_o is pulsed in the next cycle. The measurement is good if |cnt_q - EXP_HALF| <= TOL.
  - MEASURE: a good measurement increments good_cnt. A bad one clears good_cnt, with no error raised. Reaching good_cnt == LOCK_COUNT moves to LOCKED.
  - LOCKED: a bad measurement sets err_o and returns to MEASURE with good_cnt = 0.
  - LOCKED timeout: cnt_q > EXP_HALF+TOL with no edge in that cycle sets err_o and returns to MEASURE. Timeout is not checked in MEASURE.
  - en_i=0 from any state forces IDLE next cycle and clears cnt and good_cnt. half_period_o and err_o hold.
- err_o: set and err_clr_i in the same cycle leaves err_o = 1 (set wins). Only rst_i or err_clr_i clears it.
- locked_o is registered and equals (state == LOCKED).
- Width rule: comparisons are unsigned in CNT_W+1 bits so EXP_HALF+TOL cannot overflow.

Decomposition:
- Shared package: state encoding constants (IDLE=0, MEASURE=1, LOCKED=2) and the default EXP_HALF/TOL values, both also used by the divider bench.
- Sub-module sync_edge_det: SYNC_STAGES flop chain plus edge register. Outputs rise/fall strobes. Parameter SYNC_STAGES.

Test Plan:
- div_clk_i toggling every 11 cycles, en_i=1 -> first strobe 3 cycles after the toggle; half_period_o=11 on each meas_valid_o; locked_o rises one cycle after the 4th good measurement; err_o=0.
- Locked, then a single half-period of 15 -> err_o=1, locked_o=0 next cycle; relock after 4 more 11-cycle halves; err_o stays 1.
- Locked, div_clk_i held constant -> err_o=1 in the cycle after cnt_q reaches 13; half_period_o retains 11.
- Half-periods of 10 and 12 alternating -> locks (within TOL); a half-period of 9 in MEASURE -> good_cnt reset, no err_o.
- err_clr_i asserted in the same cycle as a timeout -> err_o stays 1; err_clr_i alone one cycle later -> err_o=0.
- rst_i pulsed mid-lock, and separately en_i dropped -> rst_i clears all outputs; en_i=0 yields IDLE with no strobes, half_period_o held, first edge after re-enable not measured.
